match_evt_queue: RTL and testbench
==================================

# match_evt_queue

Event-queue stage directly downstream of the LCT/L1A matching logic. Tags every L1A-match outcome (good match or overlap-suppressed miss) with a 12-bit L1A number and buffers it in a shallow first-word-fall-through queue. The queue is drained by the readout engine through a valid/ack handshake. Also keeps saturating outcome counters for slow-control readback.

## Interface
Parameters:
- TMR, 0, 1 = triplicate and majority-vote queue pointers and L1A counter
- DEPTH, 8, queue entries (power of two, 4..16)
- L1AW, 12, L1A-number width

Ports:
- CLK  in  1  system clock (40 MHz BX clock)
- RST  in  1  reset; asynchronous, active-high
- GIN  in  1  L1A pulse, one cycle per L1A
- L1A_RST  in  1  synchronous L1A-number reset (resync)
- GMATCH  in  1  good match, one cycle, 2 cycles after its GIN
- MISS_MATCH  in  1  overlap-suppressed match, same timing as GMATCH
- MATCHR  in  1  LCT had an L1A in its window
- NO_MATCH  in  1  LCT had no L1A in its window
- CNT_CLR  in  1  synchronous clear of all counters
- EVT_ACK  in  1  readout consumed head entry
- EVT_VALID  out  1  head entry valid
- EVT_L1ANUM  out  L1AW  head-entry L1A number
- EVT_MISS  out  1  head entry is a miss
- EMPTY / FULL  out  1  queue status
- OVFL  out  1  sticky: an entry was dropped
- MATCH_CNT, MISS_CNT, NOMATCH_CNT, DROP_CNT  out  16 each  saturating counters

## Operation
- L1A counter: on GIN, l1a_cnt <= l1a_cnt+1, wraps 4095->0. First L1A after reset is number 1. L1A_RST sets 0; L1A_RST with GIN in the same cycle sets 1.
- Two-stage tag pipeline carries the post-increment value aligned with GIN+2, so the pushed tag belongs to the L1A that produced the match.
- Push when GMATCH | MISS_MATCH; entry = {tag, MISS_MATCH}. If both are high in the same cycle (illegal), push once, miss=1.
- Pop when EVT_VALID & EVT_ACK. EVT_ACK with EVT_VALID=0 is ignored.
- Full, push, no pop: entry dropped, OVFL set (cleared only by RST), DROP_CNT++.
- Full, push and pop in the same cycle: both accepted, occupancy unchanged, no drop.
- Empty, push and pop in the same cycle: pop ignored; entry is stored.
- Counters +1 on GMATCH, MISS_MATCH, NO_MATCH, and drop respectively. They saturate at 0xFFFF. CNT_CLR zeroes them and wins over a coincident increment. MATCHR has no counter; it only qualifies NO_MATCH sanity checks in the bench.
- TMR=1: write/read pointers, occupancy and l1a_cnt are held in three copies with majority vote each cycle. The queue RAM is not triplicated.

## Timing
- Reset values: EVT_VALID=0, EVT_L1ANUM=0, EVT_MISS=0, EMPTY=1, FULL=0, OVFL=0, all counters 0, l1a_cnt=0, pointers 0.
- Push-to-EVT_VALID latency is 1 cycle; head data is stable while EVT_VALID=1 and no ack.
- After a pop, the next entry is presented on the following cycle. Back-to-back acks drain one entry per cycle.
- FULL and EMPTY are registered and reflect occupancy after the current cycle's push/pop.
- Counter outputs update 1 cycle after the event.
- RST mid-operation: queue contents discarded immediately (asynchronous). The first push after release is a normal push.

## Configuration
- MATCH_EVT_CNT_EN defined: the four counters and CNT_CLR logic are built.
- MATCH_EVT_CNT_EN undefined: the counter outputs are tied to 0 and CNT_CLR is ignored. The queue, L1A tagging and OVFL are unaffected.

## Structure
- Shared package holds: the DEPTH and L1AW defaults, the entry-type localparams (EVT_MATCH=0, EVT_MISS=1), the counter width (16) and the saturation value.
- One sub-module, match_evt_ram: DEPTH x (L1AW+1) distributed RAM, single write port, asynchronous read. Pointers and flags stay in the top.

## Test plan
- GIN at cycle 10, GMATCH at 12, no ack -> EVT_VALID=1 at 13, EVT_L1ANUM=1, EVT_MISS=0, MATCH_CNT=1.
- 9 matched L1As with no ack (DEPTH=8) -> FULL=1 after the 8th push; the 9th is dropped with OVFL=1 and DROP_CNT=1. Then ack 8 times -> tags 1..8 in order, EMPTY=1.
- Queue full, GMATCH and EVT_ACK in the same cycle -> no drop, FULL stays 1, the new tag appears last.
- L1A_RST at tag 4095, then GIN -> tag 1. Separately, 4096 GINs without reset -> wrap to 0.
- MISS_MATCH pulse -> entry with EVT_MISS=1 and MISS_CNT=1. CNT_CLR coincident with NO_MATCH -> NOMATCH_CNT=0.
- RST asserted mid-way with 3 entries queued -> same-cycle EMPTY=1, EVT_VALID=0, counters 0. Force 70000 NO_MATCH pulses -> NOMATCH_CNT holds at 0xFFFF.

Source files
------------

// File: rtl/match_evt_queue_pkg.sv
// -----------------------------------------------------------------------------
// match_evt_queue_pkg
// Shared constants for the L1A-match event queue: default geometry, the
// entry-type encoding stored in the queue's LSB, and the saturating counter
// width/limit with a small increment helper.
// Optional feature macro used by the top: MATCH_EVT_CNT_EN (outcome counters).
// -----------------------------------------------------------------------------
package match_evt_queue_pkg;

    localparam int DEPTH_DEF = 8;   // queue entries
    localparam int L1AW_DEF  = 12;  // L1A-number width

    // Entry type, stored as the LSB of each queue word.
    localparam logic EVT_MATCH = 1'b0;
    localparam logic EVT_MISS  = 1'b1;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/match_evt_ram.sv
// -----------------------------------------------------------------------------
// match_evt_ram
// DEPTH x WIDTH distributed RAM holding the queued events: one synchronous
// write port, one asynchronous read port (gives first-word-fall-through at the
// queue head without an extra register stage).
// Ports:
//   i_clk    in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_raddr  in   read address
//   o_rdata  out  read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module match_evt_ram
    import match_evt_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = L1AW_DEF + 1
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset on purpose -- a reset would stop it mapping
    // to LUT RAM; stale words are never visible because the top qualifies the
    // head with its (reset) occupancy flags.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/match_evt_queue.sv
// -----------------------------------------------------------------------------
// match_evt_queue
// Tags every L1A-match outcome (good match or overlap-suppressed miss) with the
// L1A number of the L1A that produced it and buffers it in a shallow
// first-word-fall-through queue drained through a valid/ack handshake.
// Optional saturating outcome counters are built when MATCH_EVT_CNT_EN is
// defined; otherwise the counter outputs read 0 and CNT_CLR is ignored.
//
// Parameters: TMR (triplicate + vote pointers, occupancy, L1A counter),
//             DEPTH (power of two, 4..16), L1AW (L1A-number width).
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   GIN                 L1A pulse
//   L1A_RST             synchronous L1A-number reset (resync)
//   GMATCH, MISS_MATCH  match outcomes, 2 cycles after their GIN
//   MATCHR, NO_MATCH    LCT window status (NO_MATCH is counted)
//   CNT_CLR             synchronous clear of all counters
//   EVT_ACK             readout consumed the head entry
//   EVT_VALID, EVT_L1ANUM, EVT_MISS   queue head
//   EMPTY, FULL         registered queue status
//   OVFL                sticky drop flag (cleared by RST only)
//   MATCH_CNT, MISS_CNT, NOMATCH_CNT, DROP_CNT   saturating counters
// -----------------------------------------------------------------------------
module match_evt_queue #(
    parameter int TMR   = 0,
    parameter int DEPTH = match_evt_queue_pkg::DEPTH_DEF,
    parameter int L1AW  = match_evt_queue_pkg::L1AW_DEF
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  GIN,
    input  logic                                  L1A_RST,
    input  logic                                  GMATCH,
    input  logic                                  MISS_MATCH,
    input  logic                                  MATCHR,
    input  logic                                  NO_MATCH,
    input  logic                                  CNT_CLR,
    input  logic                                  EVT_ACK,
    output logic                                  EVT_VALID,
    output logic [L1AW-1:0]                       EVT_L1ANUM,
    output logic                                  EVT_MISS,
    output logic                                  EMPTY,
    output logic                                  FULL,
    output logic                                  OVFL,
    output logic [match_evt_queue_pkg::CNT_W-1:0] MATCH_CNT,
    output logic [match_evt_queue_pkg::CNT_W-1:0] MISS_CNT,
    output logic [match_evt_queue_pkg::CNT_W-1:0] NOMATCH_CNT,
    output logic [match_evt_queue_pkg::CNT_W-1:0] DROP_CNT
);

    import match_evt_queue_pkg::*;

    localparam int PW = $clog2(DEPTH);      // pointer width
    localparam int OW = PW + 1;             // occupancy width (0..DEPTH)
    localparam int EW = L1AW + 1;           // entry: {tag, type}
    localparam int SW = 2 * PW + OW + L1AW; // protected state vector width

    // Voted (current) and next values of the protected state.
    logic [PW-1:0]   w_wr_ptr,  w_wr_ptr_nxt;
    logic [PW-1:0]   w_rd_ptr,  w_rd_ptr_nxt;
    logic [OW-1:0]   w_occ,     w_occ_nxt;
    logic [L1AW-1:0] w_l1a,     w_l1a_nxt;
    logic [SW-1:0]   w_state,   w_state_nxt;

    logic            w_push_req, w_push, w_pop, w_drop;
    logic [EW-1:0]   w_wdata, w_head;

    logic            r_empty, r_full, r_ovfl;
    logic [L1AW-1:0] r_tag1, r_tag2;

    // ---------------------------------------------------------------- control
    // A pop needs a presented head, so an ack on an empty queue is ignored
    // even if a push lands in the same cycle.
    assign w_pop      = EVT_VALID & EVT_ACK;
    assign w_push_req = GMATCH | MISS_MATCH;
    // Full with a coincident pop frees the slot this same edge, so no drop.
    assign w_drop     = w_push_req & (w_occ == OW'(DEPTH)) & ~w_pop;
    assign w_push     = w_push_req & ~w_drop;

    // NOTE: every output of this block is given a value on every path, so no
    // latch can be inferred.
    always_comb begin
        w_wr_ptr_nxt = w_wr_ptr + PW'(w_push);   // DEPTH is 2**PW: wraps naturally
        w_rd_ptr_nxt = w_rd_ptr + PW'(w_pop);
        w_occ_nxt    = w_occ + OW'(w_push) - OW'(w_pop);
        w_l1a_nxt    = w_l1a;
        if (L1A_RST) begin
            w_l1a_nxt = L1AW'(GIN);              // resync with L1A: this L1A is #1
        end else if (GIN) begin
            w_l1a_nxt = w_l1a + L1AW'(1);
        end
    end

    assign w_state_nxt = {w_wr_ptr_nxt, w_rd_ptr_nxt, w_occ_nxt, w_l1a_nxt};
    assign {w_wr_ptr, w_rd_ptr, w_occ, w_l1a} = w_state;

    // ------------------------------------------------------ protected state
    generate
        if (TMR != 0) begin : g_tmr
            // Three copies reload from the voted next value every cycle, so a
            // single upset is scrubbed on the following edge. Keep/dont-touch
            // constraints in the implementation flow stop the copies merging.
            logic [SW-1:0] r_state [3];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int k = 0; k < 3; k++) r_state[k] <= '0;
                end else begin
                    for (int k = 0; k < 3; k++) r_state[k] <= w_state_nxt;
                end
            end

            assign w_state = (r_state[0] & r_state[1]) |
                             (r_state[0] & r_state[2]) |
                             (r_state[1] & r_state[2]);
        end else begin : g_simplex
            logic [SW-1:0] r_state;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) r_state <= '0;
                else     r_state <= w_state_nxt;
            end

            assign w_state = r_state;
        end
    endgenerate

    // -------------------------------------------- flags and tag pipeline
    // The tag pipeline always shifts the post-increment L1A number, so two
    // cycles later r_tag2 holds the number of the L1A that the match belongs to.
    // NOTE: non-blocking assignments here let r_tag2 take the old r_tag1;
    // blocking ones would collapse the two stages into one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovfl  <= 1'b0;
            r_tag1  <= '0;
            r_tag2  <= '0;
        end else begin
            r_empty <= (w_occ_nxt == '0);
            r_full  <= (w_occ_nxt == OW'(DEPTH));
            r_ovfl  <= r_ovfl | w_drop;
            r_tag1  <= w_l1a_nxt;
            r_tag2  <= r_tag1;
        end
    end

    // An illegal GMATCH+MISS_MATCH pair is stored once, as a miss.
    assign w_wdata = {r_tag2, (MISS_MATCH ? match_evt_queue_pkg::EVT_MISS : EVT_MATCH)};

    match_evt_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (w_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_head)
    );

    // Head outputs are forced to 0 while empty so unwritten RAM never leaks out.
    assign EVT_VALID  = ~r_empty;
    assign EVT_L1ANUM = EVT_VALID ? w_head[EW-1:1] : '0;
    assign EVT_MISS   = EVT_VALID & w_head[0];
    assign EMPTY      = r_empty;
    assign FULL       = r_full;
    assign OVFL       = r_ovfl;

    // --------------------------------------------------------- counters
`ifdef MATCH_EVT_CNT_EN
    logic [CNT_W-1:0] r_match_cnt, r_miss_cnt, r_nomatch_cnt, r_drop_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_nomatch_cnt <= '0;
            r_drop_cnt    <= '0;
        end else if (CNT_CLR) begin
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_nomatch_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (GMATCH)     r_match_cnt   <= sat_inc(r_match_cnt);
            if (MISS_MATCH) r_miss_cnt    <= sat_inc(r_miss_cnt);
            if (NO_MATCH)   r_nomatch_cnt <= sat_inc(r_nomatch_cnt);
            if (w_drop)     r_drop_cnt    <= sat_inc(r_drop_cnt);
        end
    end

    assign MATCH_CNT   = r_match_cnt;
    assign MISS_CNT    = r_miss_cnt;
    assign NOMATCH_CNT = r_nomatch_cnt;
    assign DROP_CNT    = r_drop_cnt;

    // MATCHR is informational only; nothing in the design consumes it.
    logic w_unused;
    assign w_unused = MATCHR;
`else
    assign MATCH_CNT   = '0;
    assign MISS_CNT    = '0;
    assign NOMATCH_CNT = '0;
    assign DROP_CNT    = '0;

    logic w_unused;
    assign w_unused = ^{MATCHR, NO_MATCH, CNT_CLR};
`endif

endmodule

// File: tb/tb_match_evt_queue.sv
`timescale 1ns/1ps
module tb_match_evt_queue;

    localparam int DEPTH = 8;
    localparam int L1AW  = 12;
    localparam int L1AM  = 1 << L1AW;

    logic        clk = 1'b0;
    logic        rst, gin, l1a_rst, gmatch, miss_match, matchr, no_match, cnt_clr, evt_ack;
    logic        evt_valid, evt_miss, empty, full, ovfl;
    logic [L1AW-1:0] evt_l1anum;
    logic [15:0] match_cnt, miss_cnt, nomatch_cnt, drop_cnt;

    always #5 clk = ~clk;

    match_evt_queue #(.TMR(0), .DEPTH(DEPTH), .L1AW(L1AW)) dut (
        .CLK(clk), .RST(rst), .GIN(gin), .L1A_RST(l1a_rst), .GMATCH(gmatch),
        .MISS_MATCH(miss_match), .MATCHR(matchr), .NO_MATCH(no_match),
        .CNT_CLR(cnt_clr), .EVT_ACK(evt_ack), .EVT_VALID(evt_valid),
        .EVT_L1ANUM(evt_l1anum), .EVT_MISS(evt_miss), .EMPTY(empty), .FULL(full),
        .OVFL(ovfl), .MATCH_CNT(match_cnt), .MISS_CNT(miss_cnt),
        .NOMATCH_CNT(nomatch_cnt), .DROP_CNT(drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counters only exist in the counter-enabled build; otherwise they read 0.
    function automatic logic [31:0] cexp(input int v);
`ifdef MATCH_EVT_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: inputs held across the edge, outputs settle by #1 after.
    task automatic cyc(input bit g, input bit lr, input bit gm, input bit mm,
                       input bit nm, input bit clr, input bit ack);
        gin = g; l1a_rst = lr; gmatch = gm; miss_match = mm;
        no_match = nm; matchr = ~nm; cnt_clr = clr; evt_ack = ack;
        @(posedge clk);
        #1;
        gin = 0; l1a_rst = 0; gmatch = 0; miss_match = 0;
        no_match = 0; matchr = 0; cnt_clr = 0; evt_ack = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // L1A followed two cycles later by its match outcome (optionally acked).
    task automatic l1a_then(input bit mm, input bit ack_on_push);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, ~mm, mm, 0, 0, ack_on_push);
    endtask

    // ---------------------------------------------------- reference model
    int m_q[$];          // entries: tag*2 + miss
    int m_l1a, m_old;    // L1A number after the previous cycle / the one before
    bit m_ovfl;
    int m_cnt[4];        // match, miss, nomatch, drop

    task automatic model_reset();
        m_q.delete();
        m_l1a = 0; m_old = 0; m_ovfl = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input bit g, input bit lr, input bit gm, input bit mm,
                              input bit nm, input bit clr, input bit ack);
        bit pop, push, drop;
        int tag, n;
        pop  = (m_q.size() > 0) && ack;
        push = gm | mm;
        drop = push && (m_q.size() == DEPTH) && !pop;
        tag  = m_old;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(tag * 2 + int'(mm));
        if (drop) m_ovfl = 1;
        if (lr)      n = g ? 1 : 0;
        else if (g)  n = (m_l1a + 1) % L1AM;
        else         n = m_l1a;
        m_old = m_l1a;
        m_l1a = n;
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            if (gm)   m_cnt[0] = (m_cnt[0] < 65535) ? m_cnt[0] + 1 : 65535;
            if (mm)   m_cnt[1] = (m_cnt[1] < 65535) ? m_cnt[1] + 1 : 65535;
            if (nm)   m_cnt[2] = (m_cnt[2] < 65535) ? m_cnt[2] + 1 : 65535;
            if (drop) m_cnt[3] = (m_cnt[3] < 65535) ? m_cnt[3] + 1 : 65535;
        end
    endtask

    task automatic model_check(input int cy);
        bit ne;
        ne = m_q.size() > 0;
        check($sformatf("rnd%0d valid", cy), evt_valid, ne);
        check($sformatf("rnd%0d l1anum", cy), evt_l1anum, ne ? m_q[0] / 2 : 0);
        check($sformatf("rnd%0d miss", cy), evt_miss, ne ? m_q[0] % 2 : 0);
        check($sformatf("rnd%0d empty", cy), empty, !ne);
        check($sformatf("rnd%0d full", cy), full, m_q.size() == DEPTH);
        check($sformatf("rnd%0d ovfl", cy), ovfl, m_ovfl);
        check($sformatf("rnd%0d match_cnt", cy), match_cnt, cexp(m_cnt[0]));
        check($sformatf("rnd%0d miss_cnt", cy), miss_cnt, cexp(m_cnt[1]));
        check($sformatf("rnd%0d nomatch_cnt", cy), nomatch_cnt, cexp(m_cnt[2]));
        check($sformatf("rnd%0d drop_cnt", cy), drop_cnt, cexp(m_cnt[3]));
    endtask

    task automatic do_reset();
        rst = 1;
        gin = 0; l1a_rst = 0; gmatch = 0; miss_match = 0;
        no_match = 0; matchr = 0; cnt_clr = 0; evt_ack = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    // ----------------------------------------------------- directed table
    typedef struct {
        bit g, lr, gm, mm, ack;              // inputs for the cycle
        bit valid; int num; bit miss, emp;   // outputs after the edge
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl = '{
            '{1,0,0,0,0, 0,0,0,1},   // L1A #1
            '{0,0,0,0,0, 0,0,0,1},
            '{0,0,1,0,0, 1,1,0,0},   // match tagged 1, visible next cycle
            '{1,0,0,0,0, 1,1,0,0},   // L1A #2, head stable
            '{0,0,0,0,0, 1,1,0,0},
            '{0,0,0,1,0, 1,1,0,0},   // miss tagged 2 queued behind
            '{0,0,0,0,1, 1,2,1,0},   // pop -> miss entry presented
            '{0,0,0,0,1, 0,0,0,1},   // pop -> empty
            '{0,0,0,0,1, 0,0,0,1},   // ack on empty ignored
            '{1,0,1,0,1, 1,2,0,0},   // empty: push+ack -> stored, L1A #3
            '{0,0,1,1,0, 1,2,0,0},   // both outcomes: one entry, miss
            '{0,0,0,0,1, 1,2,1,0},
            '{1,1,0,0,0, 1,2,1,0},   // resync with L1A -> number 1
            '{0,0,0,0,1, 0,0,0,1},
            '{0,0,1,0,0, 1,1,0,0},   // tag after resync is 1
            '{0,0,0,0,1, 0,0,0,1}
        };

        do_reset();
        check("rst valid", evt_valid, 0);
        check("rst l1anum", evt_l1anum, 0);
        check("rst miss", evt_miss, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst ovfl", ovfl, 0);
        check("rst match_cnt", match_cnt, 0);
        check("rst drop_cnt", drop_cnt, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].g, tbl[i].lr, tbl[i].gm, tbl[i].mm, 0, 0, tbl[i].ack);
            check($sformatf("tbl%0d valid", i), evt_valid, tbl[i].valid);
            check($sformatf("tbl%0d l1anum", i), evt_l1anum, tbl[i].num);
            check($sformatf("tbl%0d miss", i), evt_miss, tbl[i].miss);
            check($sformatf("tbl%0d empty", i), empty, tbl[i].emp);
        end

        // ---- first L1A at cycle 10, match at 12, visible at 13
        do_reset();
        idle(10);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("lat pre valid", evt_valid, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("lat valid", evt_valid, 1);
        check("lat l1anum", evt_l1anum, 1);
        check("lat miss", evt_miss, 0);
        check("lat match_cnt", match_cnt, cexp(1));

        // ---- fill, overflow, drain in order
        do_reset();
        for (int k = 1; k <= 8; k++) l1a_then(0, 0);
        check("fill full", full, 1);
        check("fill ovfl", ovfl, 0);
        l1a_then(0, 0);
        check("drop full", full, 1);
        check("drop ovfl", ovfl, 1);
        check("drop cnt", drop_cnt, cexp(1));
        check("drop head", evt_l1anum, 1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d tag", k), evt_l1anum, k);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        check("drain empty", empty, 1);
        check("drain valid", evt_valid, 0);
        check("drain full", full, 0);
        // refill with tags 10..17, then push+pop while full with tag 18
        for (int k = 10; k <= 17; k++) l1a_then(0, 0);
        check("refill full", full, 1);
        l1a_then(0, 1);
        check("fullpp full", full, 1);
        check("fullpp drop_cnt", drop_cnt, cexp(1));
        for (int k = 11; k <= 18; k++) begin
            check($sformatf("fullpp drain%0d", k), evt_l1anum, k);
            cyc(0, 0, 0, 0, 0, 0, 1);
        end
        check("fullpp empty", empty, 1);
        check("fullpp ovfl sticky", ovfl, 1);

        // ---- L1A number wrap and resync
        do_reset();
        for (int k = 0; k < L1AM - 1; k++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("tag 4095", evt_l1anum, L1AM - 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        l1a_then(0, 0);
        check("resync tag", evt_l1anum, 1);
        do_reset();
        for (int k = 0; k < L1AM; k++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("wrap valid", evt_valid, 1);
        check("wrap tag", evt_l1anum, 0);

        // ---- miss entry, counter clear priority
        do_reset();
        l1a_then(1, 0);
        check("miss flag", evt_miss, 1);
        check("miss tag", evt_l1anum, 1);
        check("miss_cnt", miss_cnt, cexp(1));
        check("miss match_cnt", match_cnt, cexp(0));
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        check("nomatch 3", nomatch_cnt, cexp(3));
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("clr nomatch", nomatch_cnt, 0);
        check("clr miss_cnt", miss_cnt, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("post clr nomatch", nomatch_cnt, cexp(1));

        // ---- asynchronous reset with 3 entries queued
        l1a_then(0, 0);
        l1a_then(0, 0);
        check("pre rst valid", evt_valid, 1);
        #2 rst = 1;
        #1;
        check("async rst empty", empty, 1);
        check("async rst valid", evt_valid, 0);
        check("async rst l1anum", evt_l1anum, 0);
        check("async rst nomatch", nomatch_cnt, 0);
        check("async rst miss_cnt", miss_cnt, 0);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        l1a_then(0, 0);
        check("post rst valid", evt_valid, 1);
        check("post rst tag", evt_l1anum, 1);
        check("post rst empty", empty, 0);

`ifdef MATCH_EVT_CNT_EN
        // ---- saturation
        do_reset();
        for (int k = 0; k < 70000; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        check("nomatch sat", nomatch_cnt, 16'hFFFF);
`endif

        // ---- randomized run against the model
        do_reset();
        for (int cy = 0; cy < 1500; cy++) begin
            bit g, lr, gm, mm, nm, clr, ack;
            int r;
            g   = ($urandom_range(0, 2) == 0);
            lr  = ($urandom_range(0, 63) == 0);
            r   = $urandom_range(0, 9);
            gm  = (r <= 2) || (r == 4);
            mm  = (r == 3) || (r == 4);
            nm  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 99) == 0);
            // alternate slow and fast drain phases to reach full and empty
            ack = ((cy / 200) % 2 == 0) ? ($urandom_range(0, 5) == 0)
                                        : ($urandom_range(0, 3) != 0);
            cyc(g, lr, gm, mm, nm, clr, ack);
            model_step(g, lr, gm, mm, nm, clr, ack);
            model_check(cy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
